// File: rtl/button_debouncer.sv
// Per-channel 2-flop synchronizer, debounce counter and press/release strobes, plus a shared press counter.
// Optional hold detector (long_press) is built only when DEBOUNCE_LONG_PRESS_EN is defined.
module button_debouncer #(
    parameter int N           = 5,
    parameter int DB_CYCLES   = 12000,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int LONG_CYCLES = 12000000
) (
    input  logic         clk_i,
    input  logic         resetq_i,
    input  logic [N-1:0] pin_i,
    output logic [N-1:0] level_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o,
    output logic [7:0]   press_count_o,
    output logic [N-1:0] long_press_o
);

    localparam int              DB_W   = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : g_db_chk
        $error("DB_CYCLES must be at least 2");
    end
    if (LONG_CYCLES < 2) begin : g_long_chk
        $error("LONG_CYCLES must be at least 2");
    end

    function automatic logic [7:0] popcount(input logic [N-1:0] v);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s = s + {7'd0, v[i]};
        end
        return s;
    endfunction

    // Internally a 1 always means "pressed", whatever the pin polarity.
    logic [N-1:0] pin_n;
    assign pin_n = ACTIVE_LOW ? ~pin_i : pin_i;

    logic [N-1:0]    sync0_q, sync1_q;
    logic [N-1:0]    level_q, level_d;
    logic [N-1:0]    press_q, press_d;
    logic [N-1:0]    release_q, release_d;
    logic [DB_W-1:0] db_cnt_q [N];
    logic [DB_W-1:0] db_cnt_d [N];
    logic [7:0]      press_count_q, press_count_d;

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N; i++) begin
            db_cnt_d[i] = '0;
            if (sync1_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    level_d[i]   = sync1_q[i];
                    press_d[i]   = sync1_q[i];
                    release_d[i] = ~sync1_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        press_count_d = press_count_q + popcount(press_q);
    end

    always_ff @(posedge clk_i) begin
        if (!resetq_i) begin
            sync0_q       <= '0;
            sync1_q       <= '0;
            level_q       <= '0;
            press_q       <= '0;
            release_q     <= '0;
            press_count_q <= '0;
            for (int i = 0; i < N; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync0_q       <= pin_n;
            sync1_q       <= sync0_q;
            level_q       <= level_d;
            press_q       <= press_d;
            release_q     <= release_d;
            press_count_q <= press_count_d;
            for (int i = 0; i < N; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign level_o       = level_q;
    assign press_o       = press_q;
    assign release_o     = release_q;
    assign press_count_o = press_count_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int              LP_W   = $clog2(LONG_CYCLES);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_CYCLES - 1);

    logic [LP_W-1:0] hold_q [N];
    logic [LP_W-1:0] hold_d [N];
    logic [N-1:0]    fired_q, fired_d;
    logic [N-1:0]    long_q, long_d;

    // A release landing on the threshold cycle wins: counter clears, no pulse.
    always_comb begin
        fired_d = fired_q;
        long_d  = '0;
        for (int i = 0; i < N; i++) begin
            hold_d[i] = hold_q[i];
            if (!level_d[i]) begin
                hold_d[i]  = '0;
                fired_d[i] = 1'b0;
            end else if (level_q[i]) begin
                if (hold_q[i] == LP_MAX) begin
                    long_d[i]  = ~fired_q[i];
                    fired_d[i] = 1'b1;
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetq_i) begin
            fired_q <= '0;
            long_q  <= '0;
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            fired_q <= fired_d;
            long_q  <= long_d;
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign long_press_o = long_q;
`else
    assign long_press_o = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: vector table, directed corner sequences and random pins against a reference model.
module tb_button_debouncer;

    localparam int N    = 5;
    localparam int DB   = 4;
    localparam int LONG = 10;

    logic         clk = 1'b0;
    logic         resetq = 1'b0;
    logic [N-1:0] pin = '1;
    logic [N-1:0] level, press, rel, lp;
    logic [7:0]   pcnt;

    int n_checks = 0;
    int n_errors = 0;

    button_debouncer #(
        .N(N), .DB_CYCLES(DB), .ACTIVE_LOW(1'b1), .LONG_CYCLES(LONG)
    ) dut (
        .clk_i(clk), .resetq_i(resetq), .pin_i(pin),
        .level_o(level), .press_o(press), .release_o(rel),
        .press_count_o(pcnt), .long_press_o(lp)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Reference model: pressed state is accepted once the last DB synced samples all disagree with it.
    logic [N-1:0] m_s0 = '0, m_s1 = '0;
    logic [N-1:0] m_hist [DB];
    logic [N-1:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0;
    logic [7:0]   m_cnt = '0;
    int           m_age [N];

    task automatic model_edge(input logic [N-1:0] p, input logic rq);
        logic [N-1:0] nl, np, nr, nlong;
        logic         all_diff;
        if (!rq) begin
            m_s0 = '0; m_s1 = '0;
            for (int k = 0; k < DB; k++) m_hist[k] = '0;
            m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_cnt = '0;
            for (int c = 0; c < N; c++) m_age[c] = 0;
        end else begin
            m_cnt = m_cnt + 8'($countones(m_press));
            for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_s1;
            nl = m_level; np = '0; nr = '0; nlong = '0;
            for (int c = 0; c < N; c++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (m_hist[k][c] == m_level[c]) all_diff = 1'b0;
                if (all_diff) begin
                    nl[c] = ~m_level[c];
                    np[c] = nl[c];
                    nr[c] = m_level[c];
                end
                if (nl[c] && m_level[c]) m_age[c] = m_age[c] + 1;
                else                     m_age[c] = 0;
`ifdef DEBOUNCE_LONG_PRESS_EN
                nlong[c] = nl[c] && m_level[c] && (m_age[c] == LONG);
`endif
            end
            m_level = nl; m_press = np; m_rel = nr; m_long = nlong;
            m_s1 = m_s0;
            m_s0 = ~p;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [N-1:0] p, input logic rq);
        logic [27:0] a, e;
        pin = p;
        resetq = rq;
        @(posedge clk);
        model_edge(p, rq);
        #1;
        a = {level, press, rel, pcnt, lp};
        e = {m_level, m_press, m_rel, m_cnt, m_long};
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL model: got lvl=%b prs=%b rel=%b cnt=%0d long=%b expected lvl=%b prs=%b rel=%b cnt=%0d long=%b (t=%0t)",
                     level, press, rel, pcnt, lp, m_level, m_press, m_rel, m_cnt, m_long, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0] pin;
        logic         rq;
        logic [N-1:0] lvl, prs, rls;
        logic [7:0]   cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int rep, input logic [N-1:0] p, input logic rq, input logic [N-1:0] l,
                       input logic [N-1:0] pr, input logic [N-1:0] rl, input logic [7:0] c);
        vec_t v;
        v.pin = p; v.rq = rq; v.lvl = l; v.prs = pr; v.rls = rl; v.cnt = c;
        for (int i = 0; i < rep; i++) tbl.push_back(v);
    endtask

    initial begin
        int n, iters, pulses, pulse_at;
        logic seen;
        logic [N-1:0] rp;

        for (int k = 0; k < DB; k++) m_hist[k] = '0;
        for (int c = 0; c < N; c++) m_age[c] = 0;

        // Reset, clean press on pin 0, short glitch on pin 2
        add(3, 5'b11111, 1'b0, 5'b00000, 5'b00000, 5'b00000, 8'd0);
        add(1, 5'b11111, 1'b1, 5'b00000, 5'b00000, 5'b00000, 8'd0);
        add(5, 5'b11110, 1'b1, 5'b00000, 5'b00000, 5'b00000, 8'd0);
        add(1, 5'b11110, 1'b1, 5'b00001, 5'b00001, 5'b00000, 8'd0);
        add(1, 5'b11110, 1'b1, 5'b00001, 5'b00000, 5'b00000, 8'd1);
        add(3, 5'b11010, 1'b1, 5'b00001, 5'b00000, 5'b00000, 8'd1);
        add(8, 5'b11110, 1'b1, 5'b00001, 5'b00000, 5'b00000, 8'd1);
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].pin, tbl[i].rq);
            chk($sformatf("vec%0d_level", i), int'(level), int'(tbl[i].lvl));
            chk($sformatf("vec%0d_press", i), int'(press), int'(tbl[i].prs));
            chk($sformatf("vec%0d_release", i), int'(rel), int'(tbl[i].rls));
            chk($sformatf("vec%0d_count", i), int'(pcnt), int'(tbl[i].cnt));
        end

        // Bounce 0/1/0 on pin 1, then held
        tick(5'b11100, 1'b1);
        tick(5'b11110, 1'b1);
        tick(5'b11100, 1'b1);
        n = 1;
        while (!press[1] && n < 12) begin tick(5'b11100, 1'b1); n++; end
        chk("bounce_latency", n, 6);
        tick(5'b11100, 1'b1);
        chk("bounce_count", int'(pcnt), 2);

        // Release of pins 0 and 1 together
        n = 1;
        tick(5'b11111, 1'b1);
        while (rel == '0 && n < 12) begin tick(5'b11111, 1'b1); n++; end
        chk("release_latency", n, 6);
        chk("release_bits", int'(rel), int'(5'b00011));
        repeat (3) tick(5'b11111, 1'b1);

        // Pins 4..1 fall together
        n = 1;
        tick(5'b00001, 1'b1);
        while (press == '0 && n < 12) begin tick(5'b00001, 1'b1); n++; end
        chk("simul_latency", n, 6);
        chk("simul_press", int'(press), int'(5'b11110));
        tick(5'b00001, 1'b1);
        chk("simul_count", int'(pcnt), 6);
        repeat (8) tick(5'b11111, 1'b1);

        // Count up to 254, then across the wrap
        iters = 0;
        while (pcnt != 8'd254 && iters < 300) begin
            repeat (7) tick(5'b11110, 1'b1);
            repeat (7) tick(5'b11111, 1'b1);
            iters++;
        end
        chk("preload_254", int'(pcnt), 254);
        repeat (7) tick(5'b11110, 1'b1);
        chk("wrap_255", int'(pcnt), 255);
        repeat (7) tick(5'b11111, 1'b1);
        repeat (7) tick(5'b11110, 1'b1);
        chk("wrap_0", int'(pcnt), 0);
        repeat (7) tick(5'b11111, 1'b1);

        // Reset while pin 0 is mid-qualification, button held through reset
        seen = 1'b0;
        repeat (4) begin tick(5'b11110, 1'b1); seen = seen | press[0]; end
        tick(5'b11110, 1'b0);
        chk("rst_mid_nostrobe", int'(seen | press[0]), 0);
        chk("rst_mid_level", int'(level), 0);
        n = 1;
        tick(5'b11110, 1'b1);
        while (!press[0] && n < 12) begin tick(5'b11110, 1'b1); n++; end
        chk("rst_requalify", n, 6);
        repeat (8) tick(5'b11111, 1'b1);

        // Long hold on pin 3
        n = 0;
        while (!level[3] && n < 20) begin tick(5'b10111, 1'b1); n++; end
        chk("long_level_rise", int'(level[3]), 1);
        pulses = 0;
        pulse_at = 0;
        for (int k = 1; k <= 30; k++) begin
            tick(5'b10111, 1'b1);
            if (lp[3]) begin
                pulses++;
                if (pulse_at == 0) pulse_at = k;
            end
        end
`ifdef DEBOUNCE_LONG_PRESS_EN
        chk("long_delay", pulse_at, LONG);
        chk("long_once", pulses, 1);
`else
        chk("long_absent", pulses, 0);
`endif
        repeat (8) tick(5'b11111, 1'b1);

        // Random pins at several bounce rates, with rare resets
        rp = '1;
        for (int ph = 0; ph < 3; ph++) begin
            int lim;
            lim = (ph == 0) ? 3 : (ph == 1) ? 8 : 20;
            for (int c = 0; c < 1500; c++) begin
                for (int ch = 0; ch < N; ch++)
                    if ($urandom_range(0, lim) == 0) rp[ch] = ~rp[ch];
                tick(rp, $urandom_range(0, 499) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
